sc_et_stream_decoder: RTL
=========================

Name: sc_et_stream_decoder

Overview:
- Stochastic-to-binary converter for unipolar bitstreams of length N = 2^WIDTH; counts ones and returns the binary value.
- Terminates the stream early once the top PREC bits of the final count are fixed regardless of the samples still to come.
- Sits at the consumer end of the stochastic datapath, after the stream generators driven by the bit-parallel counters.

Parameters:
- WIDTH, 8, log2 of the full stream length N; the counters are WIDTH+1 bits.
- PREC, 8, result precision in bits, 1..WIDTH; S = WIDTH-PREC is the number of low bits that are don't-care.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new conversion; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE from any state
- in_valid  input  1  a stream sample is present
- in_bit  input  1  stream sample value
- in_ready  output  1  decoder accepts a sample this cycle
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_value  output  WIDTH+1  ones count, low S bits forced to 0
- out_cycles  output  WIDTH+1  number of samples consumed
- out_early  output  1  1 if terminated before N samples

Behaviour:
- Reset (async, rst_n=0): state IDLE; ones count c=0; sample count k=0; all outputs 0.
- States:
  - IDLE: start=1 -> clear c and k, go to RUN.
  - RUN: in_ready=1; accept when in_valid & in_ready.
  - DONE: out_valid=1 held until out_ready.
- RUN, on each accept:
  - k' = k+1; c' = c + in_bit.
  - r' = N - k'.
  - Termination test on the updated values: (c' >> S) == ((c' + r') >> S), computed in WIDTH+2 bits, no overflow.
  - If the test is true, move to DONE on the same edge and latch the outputs:
    - out_value = (c' >> S) << S
    - out_cycles = k'
    - out_early = (k' != N)
- At k' = N, r' = 0, so the test is always true: a stream never exceeds N samples.
- The test can never pass at k = 0, since 2^PREC >= 2.
- With PREC = WIDTH (S = 0), termination occurs only at k = N.
- No accept when in_valid=0; counters hold.
- out_valid rises the cycle after the terminating sample; in_ready is 0 in that same cycle.
- DONE with out_ready=1 -> IDLE next cycle; out_valid drops; out_* hold their last values until the next start.
- start in RUN or DONE is ignored.
- If start and out_ready are both high in DONE, go to IDLE only; a new start is required.
- abort=1 -> IDLE next edge with counters cleared and out_valid=0. abort has priority over start and over sample accept in the same cycle.
- Async reset mid-conversion: immediate return to the reset state; the partial result is discarded.
- in_bit is don't-care when not accepted. There is no X-propagation requirement on unaccepted samples.

Test Plan:
- Full stream, no early exit:
  - WIDTH=8, PREC=8, start, 256 ones with in_valid=1 continuously -> out_valid one cycle after the 256th accept.
  - out_value=256, out_cycles=256, out_early=0.
- All-zero stream:
  - WIDTH=8, PREC=2 (S=6) -> terminates at k=193 (r=63).
  - out_value=0, out_cycles=193, out_early=1.
  - in_ready=0 from the following cycle.
- Half stream:
  - PREC=2, 128 ones then zeros -> terminate at k=193.
  - out_value=128, out_cycles=193, out_early=1.
- Gapped input and backpressure:
  - PREC=8, alternating 1/0 with in_valid toggled every other cycle -> count unaffected by gaps.
  - out_value=128, out_cycles=256.
  - Hold out_ready=0 for 5 cycles: out_valid and out_* stable; IDLE one cycle after out_ready=1.
- Abort and reset:
  - abort at k=50 with in_valid=1 -> IDLE, that sample not counted, out_valid stays 0.
  - A new start gives fresh counts.
  - Repeat with rst_n pulsed low mid-stream -> all outputs 0 immediately.
- Start ignored:
  - start pulsed during RUN and during DONE -> no counter clear, result unchanged.
  - A start after returning to IDLE begins a new conversion.

Source files
------------

// File: rtl/sc_et_stream_decoder.sv
// Early-terminating stochastic-to-binary decoder: counts ones in a unipolar stream of
// length 2**WIDTH and stops once the top PREC bits of the final count can no longer change.
module sc_et_stream_decoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PREC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_value,
    output logic [WIDTH:0]   out_cycles,
    output logic             out_early
);

    localparam int unsigned CW = WIDTH + 1;
    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned S  = WIDTH - PREC;

    localparam logic [CW-1:0] N_VAL    = CW'(64'(1) << WIDTH);
    localparam logic [CW-1:0] LOW_MASK = CW'((64'(1) << S) - 64'(1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] k_q, k_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_value_q, out_value_d;
    logic [CW-1:0] out_cycles_q, out_cycles_d;
    logic          out_early_q, out_early_d;

    logic          accept_c;
    logic          term_c;
    logic [CW-1:0] c_nx_c;
    logic [CW-1:0] k_nx_c;
    logic [CW-1:0] r_nx_c;
    logic [XW-1:0] c_ext_c;
    logic [XW-1:0] sum_ext_c;

    // Updated counts and the "top bits already fixed" test on the post-accept values.
    always_comb begin
        accept_c  = (state_q == ST_RUN) && in_valid && !abort;
        k_nx_c    = k_q + CW'(1);
        c_nx_c    = c_q + CW'(in_bit);
        r_nx_c    = N_VAL - k_nx_c;
        c_ext_c   = XW'(c_nx_c);
        sum_ext_c = c_ext_c + XW'(r_nx_c);
        term_c    = ((c_ext_c >> S) == (sum_ext_c >> S));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start)              state_d = ST_RUN;
                ST_RUN:  if (accept_c && term_c) state_d = ST_DONE;
                ST_DONE: if (out_ready)          state_d = ST_IDLE;
                default:                         state_d = ST_IDLE;
            endcase
        end
    end

    // Counter and result updates plus registered handshake flags.
    always_comb begin
        c_d          = c_q;
        k_d          = k_q;
        out_value_d  = out_value_q;
        out_cycles_d = out_cycles_q;
        out_early_d  = out_early_q;
        in_ready_d   = (state_d == ST_RUN);
        out_valid_d  = (state_d == ST_DONE);
        if (abort) begin
            c_d = '0;
            k_d = '0;
        end else if ((state_q == ST_IDLE) && start) begin
            c_d          = '0;
            k_d          = '0;
            out_value_d  = '0;
            out_cycles_d = '0;
            out_early_d  = 1'b0;
        end else if (accept_c) begin
            c_d = c_nx_c;
            k_d = k_nx_c;
            if (term_c) begin
                out_value_d  = c_nx_c & ~LOW_MASK;
                out_cycles_d = k_nx_c;
                out_early_d  = (k_nx_c != N_VAL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q          <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_cycles_q <= '0;
            out_early_q  <= 1'b0;
        end else begin
            c_q          <= c_d;
            k_q          <= k_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_cycles_q <= out_cycles_d;
            out_early_q  <= out_early_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_value  = out_value_q;
    assign out_cycles = out_cycles_q;
    assign out_early  = out_early_q;

endmodule
